qram_sdram_responder: RTL and testbench

- Memory-side responder for the QRAM SDRAM command interface. Decodes controller commands (ACT/RD/WR/PRE/REF), tracks open rows per bank, stores write bursts, and returns read bursts after a fixed CAS latency.
- Sits opposite the QRAM initiator and serves as the target in QRAM integration benches and on-chip scratch use.

---
 rtl/qram_pkg.sv | 33 +++
 rtl/qram_bank_tracker.sv | 59 +++++
 rtl/qram_sdram_responder.sv | 218 +++++++++++++++++++++
 tb/tb_qram_sdram_responder.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qram_pkg.sv
// Shared definitions for the QRAM SDRAM responder.
//   qram_cmd_e   : command encoding driven by the QRAM controller
//   qram_state_e : responder FSM states
//   QRAM_DEF_*   : default CAS latency, burst length and refresh time
package qram_pkg;

    typedef enum logic [2:0] {
        QRAM_NOP = 3'd0,
        QRAM_ACT = 3'd1,
        QRAM_RD  = 3'd2,
        QRAM_WR  = 3'd3,
        QRAM_PRE = 3'd4,
        QRAM_REF = 3'd5
    } qram_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_REFRESH
    } qram_state_e;

    localparam int QRAM_DEF_CL    = 3;
    localparam int QRAM_DEF_BURST = 4;
    localparam int QRAM_DEF_TRFC  = 6;

    // Codes 6 and 7 are reserved and behave like NOP.
    function automatic logic cmd_is_active(input logic [2:0] cmd);
        return (cmd >= QRAM_ACT) && (cmd <= QRAM_REF);
    endfunction

endpackage

// File: rtl/qram_bank_tracker.sv
// Per-bank open-row bookkeeping for the QRAM responder.
//   clk, rst_n : clock and asynchronous active-low reset (closes all banks)
//   act_en     : open 'bank' with row 'row' (caller guarantees the bank is closed)
//   pre_en     : close 'bank' (closing an already closed bank is harmless)
//   open_mask  : one bit per bank, high while that bank has an open row
//   sel_open   : open flag of the bank currently addressed by 'bank'
//   sel_row    : open row of the bank currently addressed by 'bank'
//   any_open   : at least one bank is open (blocks refresh)
module qram_bank_tracker #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   act_en,
    input  logic                   pre_en,
    input  logic [BANK_W-1:0]      bank,
    input  logic [ROW_W-1:0]       row,
    output logic [2**BANK_W-1:0]   open_mask,
    output logic                   sel_open,
    output logic [ROW_W-1:0]       sel_row,
    output logic                   any_open
);

    localparam int BANKS = 2**BANK_W;

    logic [ROW_W-1:0] row_arr [BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic             open_reg;
            logic [ROW_W-1:0] row_reg;
            logic             hit;

            assign hit = (bank == BANK_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    open_reg <= 1'b0;
                    row_reg  <= '0;
                end else if (act_en && hit) begin
                    open_reg <= 1'b1;
                    row_reg  <= row;
                end else if (pre_en && hit) begin
                    open_reg <= 1'b0;
                end
            end

            assign open_mask[gi] = open_reg;
            assign row_arr[gi]   = row_reg;
        end
    endgenerate

    assign sel_open = open_mask[bank];
    assign sel_row  = row_arr[bank];
    assign any_open = |open_mask;

endmodule

// File: rtl/qram_sdram_responder.sv
// Memory-side responder for the QRAM SDRAM command interface.
// Decodes ACT/RD/WR/PRE/REF, tracks open rows, stores write bursts and
// returns read bursts CL cycles after the RD command.
//   QRAM_Clock, QRAM_ResetN : clock, asynchronous active-low reset
//   Cmd, Bank, RowAddr, ColAddr, WrData : command and write-beat inputs
//   RdData, RdValid : read beat (RdData is zero whenever RdValid is low)
//   Busy            : burst, read wait or refresh in progress
//   CmdError        : sticky illegal-command flag
//   OpenRowMask     : per-bank open-row flags
// Storage is not reset, so written words survive a reset.
module qram_sdram_responder
    import qram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int CL     = QRAM_DEF_CL,
    parameter int BURST  = QRAM_DEF_BURST,
    parameter int TRFC   = QRAM_DEF_TRFC
) (
    input  logic                  QRAM_Clock,
    input  logic                  QRAM_ResetN,
    input  logic [2:0]            Cmd,
    input  logic [BANK_W-1:0]     Bank,
    input  logic [ROW_W-1:0]      RowAddr,
    input  logic [COL_W-1:0]      ColAddr,
    input  logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     RdData,
    output logic                  RdValid,
    output logic                  Busy,
    output logic                  CmdError,
    output logic [2**BANK_W-1:0]  OpenRowMask
);

    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int LAT_W  = $clog2(CL + BURST);
    localparam int BEAT_W = $clog2(BURST + 1);
    localparam int REF_W  = $clog2(TRFC + 1);

    qram_state_e         state_reg, state_next;
    logic [LAT_W-1:0]    lat_reg,   lat_next;
    logic [BEAT_W-1:0]   beat_reg,  beat_next;
    logic [REF_W-1:0]    ref_reg,   ref_next;
    logic [BANK_W-1:0]   bank_reg,  bank_next;
    logic [ROW_W-1:0]    row_reg,   row_next;
    logic [COL_W-1:0]    col_reg,   col_next;
    logic                rd_valid_reg, rd_valid_next;
    logic                err_reg,   err_next;

    logic                sel_open, any_open;
    logic [ROW_W-1:0]    sel_row;
    logic                act_en, pre_en;
    logic                idle;

    logic                mem_we, mem_re;
    logic [ADDR_W-1:0]   mem_waddr, mem_raddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   mem_q;

    assign idle   = (state_reg == ST_IDLE);
    assign act_en = idle && (Cmd == QRAM_ACT) && !sel_open;
    assign pre_en = idle && (Cmd == QRAM_PRE);

    qram_bank_tracker #(
        .BANK_W (BANK_W),
        .ROW_W  (ROW_W)
    ) u_tracker (
        .clk       (QRAM_Clock),
        .rst_n     (QRAM_ResetN),
        .act_en    (act_en),
        .pre_en    (pre_en),
        .bank      (Bank),
        .row       (RowAddr),
        .open_mask (OpenRowMask),
        .sel_open  (sel_open),
        .sel_row   (sel_row),
        .any_open  (any_open)
    );

    always_ff @(posedge QRAM_Clock or negedge QRAM_ResetN) begin
        if (!QRAM_ResetN) begin
            state_reg    <= ST_IDLE;
            lat_reg      <= '0;
            beat_reg     <= '0;
            ref_reg      <= '0;
            bank_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lat_reg      <= lat_next;
            beat_reg     <= beat_next;
            ref_reg      <= ref_next;
            bank_reg     <= bank_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            rd_valid_reg <= rd_valid_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lat_next      = lat_reg;
        beat_next     = beat_reg;
        ref_next      = ref_reg;
        bank_next     = bank_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        rd_valid_next = 1'b0;
        err_next      = err_reg;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_waddr     = {bank_reg, row_reg, col_reg};
        mem_raddr     = {bank_reg, row_reg, col_reg};
        mem_wdata     = WrData;

        case (state_reg)
            ST_IDLE: begin
                unique case (Cmd)
                    QRAM_ACT: if (sel_open) err_next = 1'b1;
                    QRAM_WR: begin
                        if (!sel_open) begin
                            err_next = 1'b1;
                        end else begin
                            // Beat 0 is written in the command cycle itself.
                            mem_we    = 1'b1;
                            mem_waddr = {Bank, sel_row, ColAddr};
                            bank_next = Bank;
                            row_next  = sel_row;
                            col_next  = ColAddr + COL_W'(1);
                            beat_next = BEAT_W'(1);
                            if (BURST > 1) state_next = ST_WR_BURST;
                        end
                    end
                    QRAM_RD: begin
                        if (!sel_open) begin
                            err_next = 1'b1;
                        end else begin
                            bank_next  = Bank;
                            row_next   = sel_row;
                            col_next   = ColAddr;
                            lat_next   = LAT_W'(1);
                            state_next = ST_RD_WAIT;
                        end
                    end
                    QRAM_REF: begin
                        if (any_open) begin
                            err_next = 1'b1;
                        end else begin
                            ref_next   = REF_W'(1);
                            state_next = ST_REFRESH;
                        end
                    end
                    default: ;
                endcase
            end

            ST_WR_BURST: begin
                mem_we    = 1'b1;
                col_next  = col_reg + COL_W'(1);
                beat_next = beat_reg + BEAT_W'(1);
                if (beat_reg == BEAT_W'(BURST - 1)) state_next = ST_IDLE;
            end

            // The array read is registered, so the first beat is fetched on
            // the last wait edge and appears together with RdValid.
            ST_RD_WAIT: begin
                if (lat_reg == LAT_W'(CL - 1)) begin
                    state_next    = ST_RD_BURST;
                    mem_re        = 1'b1;
                    rd_valid_next = 1'b1;
                    col_next      = col_reg + COL_W'(1);
                    beat_next     = BEAT_W'(1);
                end else begin
                    lat_next = lat_reg + LAT_W'(1);
                end
            end

            ST_RD_BURST: begin
                if (beat_reg == BEAT_W'(BURST)) begin
                    state_next = ST_IDLE;
                end else begin
                    mem_re        = 1'b1;
                    rd_valid_next = 1'b1;
                    col_next      = col_reg + COL_W'(1);
                    beat_next     = beat_reg + BEAT_W'(1);
                end
            end

            ST_REFRESH: begin
                if (ref_reg == REF_W'(TRFC)) state_next = ST_IDLE;
                else                         ref_next   = ref_reg + REF_W'(1);
            end

            default: state_next = ST_IDLE;
        endcase

        // Anything other than NOP while a burst/refresh runs is illegal.
        if (!idle && cmd_is_active(Cmd)) err_next = 1'b1;
    end

    // Single-port storage; reads and writes never share a cycle.
    always_ff @(posedge QRAM_Clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_q <= mem[mem_raddr];
    end

    assign RdValid  = rd_valid_reg;
    assign RdData   = rd_valid_reg ? mem_q : '0;
    assign Busy     = !idle;
    assign CmdError = err_reg;

endmodule

// File: tb/tb_qram_sdram_responder.sv
module tb_qram_sdram_responder;

    localparam int CL    = 3;
    localparam int BURST = 4;
    localparam int TRFC  = 6;
    localparam int NCYC  = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cmd;
    logic [1:0] bank;
    logic [3:0] row, col;
    logic [7:0] wdata;
    logic [7:0] rd_data;
    logic       rd_valid, busy, cmd_error;
    logic [3:0] open_mask;

    always #5 clk = ~clk;

    qram_sdram_responder #(
        .DATA_W(8), .BANK_W(2), .ROW_W(4), .COL_W(4),
        .CL(CL), .BURST(BURST), .TRFC(TRFC)
    ) dut (
        .QRAM_Clock  (clk),
        .QRAM_ResetN (rst_n),
        .Cmd         (cmd),
        .Bank        (bank),
        .RowAddr     (row),
        .ColAddr     (col),
        .WrData      (wdata),
        .RdData      (rd_data),
        .RdValid     (rd_valid),
        .Busy        (busy),
        .CmdError    (cmd_error),
        .OpenRowMask (open_mask)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observation vector layout: {valid, data[7:0], busy, error, mask[3:0]}
    logic [14:0] e_vec [NCYC];
    logic [14:0] o_vec [NCYC];

    // Reference model: timeline of expected read beats, memory image,
    // bank state, sticky error and the busy interval [bs, be].
    bit         e_v [NCYC];
    logic [7:0] e_d [NCYC];
    logic [7:0] m_mem [1024];
    bit         m_open [4];
    logic [3:0] m_row [4];
    bit         m_err;
    int         bs = 1, be = 0;
    int         wr_left = 0;
    logic [1:0] wr_bank;
    logic [3:0] wr_row, wr_col;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        m_err   = 1'b0;
        bs      = 1;
        be      = 0;
        wr_left = 0;
        for (int k = cyc + 1; k < cyc + 32 && k < NCYC; k++) e_v[k] = 1'b0;
    endtask

    // One clock: drive inputs, let the model act on the sampled command,
    // then record expected and observed outputs for the following cycle.
    task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [3:0] r,
                        input logic [3:0] cc, input logic [7:0] wd);
        logic [3:0] cx;
        bit         busy_now;
        int         k;
        cmd = c; bank = b; row = r; col = cc; wdata = wd;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            busy_now = (cyc >= bs) && (cyc <= be);
            if (wr_left > 0) begin
                m_mem[{wr_bank, wr_row, wr_col}] = wd;
                wr_col  = wr_col + 4'd1;
                wr_left = wr_left - 1;
            end
            if (c >= 3'd1 && c <= 3'd5) begin
                if (busy_now) m_err = 1'b1;
                else begin
                    case (c)
                        3'd1: if (m_open[b]) m_err = 1'b1;
                              else begin m_open[b] = 1'b1; m_row[b] = r; end
                        3'd2: if (!m_open[b]) m_err = 1'b1;
                              else begin
                                  for (int i = 0; i < BURST; i++) begin
                                      cx = cc + 4'(i);
                                      e_v[cyc + CL + i] = 1'b1;
                                      e_d[cyc + CL + i] = m_mem[{b, m_row[b], cx}];
                                  end
                                  bs = cyc + 1;
                                  be = cyc + CL + BURST - 1;
                              end
                        3'd3: if (!m_open[b]) m_err = 1'b1;
                              else begin
                                  m_mem[{b, m_row[b], cc}] = wd;
                                  wr_left = BURST - 1;
                                  wr_bank = b;
                                  wr_row  = m_row[b];
                                  wr_col  = cc + 4'd1;
                                  bs = cyc + 1;
                                  be = cyc + BURST - 1;
                              end
                        3'd4: m_open[b] = 1'b0;
                        default: if (m_open[0] | m_open[1] | m_open[2] | m_open[3]) m_err = 1'b1;
                                 else begin bs = cyc + 1; be = cyc + TRFC; end
                    endcase
                end
            end
        end
        #1;
        k = cyc + 1;
        e_vec[k] = {e_v[k], (e_v[k] ? e_d[k] : 8'h00), ((k >= bs) && (k <= be)), m_err,
                    m_open[3], m_open[2], m_open[1], m_open[0]};
        o_vec[k] = {rd_valid, rd_data, busy, cmd_error, open_mask};
        cyc = cyc + 1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
    endtask

    task automatic wr_burst(input logic [1:0] b, input logic [3:0] c, input logic [7:0] d [4]);
        step(3'd3, b, 4'd0, c, d[0]);
        for (int i = 1; i < BURST; i++) step(3'd0, 2'd0, 4'd0, 4'd0, d[i]);
    endtask

    task automatic test_reset();
        int w0;
        rst_n = 1'b0;
        w0 = cyc;
        nop(3);
        n_checks++;
        if ({rd_valid, rd_data, busy, cmd_error, open_mask} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required 0000", {rd_valid, rd_data, busy, cmd_error, open_mask});
        end
        rst_n = 1'b1;
        nop(3);
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    // Give every word a known value so later reads have a defined reference.
    task automatic test_fill();
        int w0 = cyc;
        logic [7:0] d [4];
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 16; r++) begin
                step(3'd1, 2'(b), 4'(r), 4'd0, 8'd0);
                for (int c = 0; c < 16; c += BURST) begin
                    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
                    wr_burst(2'(b), 4'(c), d);
                end
                step(3'd4, 2'(b), 4'd0, 4'd0, 8'd0);
            end
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL fill cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_write_read();
        int w0 = cyc;
        int t, nb;
        logic [7:0] d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        step(3'd1, 2'd1, 4'd5, 4'd0, 8'd0);
        wr_burst(2'd1, 4'd2, d);
        t = cyc;
        step(3'd2, 2'd1, 4'd0, 4'd2, 8'd0);
        nop(8);
        nb = 0;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (i >= CL && i < CL + BURST) begin
                if (o_vec[t + i][14] !== 1'b1 || o_vec[t + i][13:6] !== d[i - CL]) begin
                    n_fail++;
                    $display("FAIL write_read beat %0d: valid/data %b/%h required 1/%h",
                             i - CL, o_vec[t + i][14], o_vec[t + i][13:6], d[i - CL]);
                end
            end else if (o_vec[t + i][14] !== 1'b0) begin
                n_fail++;
                $display("FAIL write_read_valid_timing offset %0d: got %b required 0", i, o_vec[t + i][14]);
            end
            if (o_vec[t + i][5] === 1'b1) nb++;
        end
        n_checks++;
        if (nb !== CL + BURST - 1) begin
            n_fail++;
            $display("FAIL read_busy_len: got %0d required %0d", nb, CL + BURST - 1);
        end
        n_checks++;
        if (open_mask !== 4'b0010) begin
            n_fail++;
            $display("FAIL open_mask_b1: got %b required 0010", open_mask);
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL write_read cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_column_wrap();
        int w0 = cyc;
        int t1, t2;
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(3'd1, 2'd0, 4'd3, 4'd0, 8'd0);
        wr_burst(2'd0, 4'd14, d);
        t1 = cyc;
        step(3'd2, 2'd0, 4'd0, 4'd0, 8'd0);
        nop(7);
        t2 = cyc;
        step(3'd2, 2'd0, 4'd0, 4'd14, 8'd0);
        nop(7);
        n_checks++;
        if (o_vec[t1 + CL][13:6] !== 8'h33 || o_vec[t1 + CL + 1][13:6] !== 8'h44) begin
            n_fail++;
            $display("FAIL wrap_rd_c0: got %h %h required 33 44", o_vec[t1 + CL][13:6], o_vec[t1 + CL + 1][13:6]);
        end
        for (int i = 0; i < BURST; i++) begin
            n_checks++;
            if (o_vec[t2 + CL + i][13:6] !== d[i]) begin
                n_fail++;
                $display("FAIL wrap_rd_c14 beat %0d: got %h required %h", i, o_vec[t2 + CL + i][13:6], d[i]);
            end
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL column_wrap cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0 = cyc;
        int t;
        logic [7:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        wr_burst(2'd1, 4'd7, d);
        t = cyc;
        step(3'd2, 2'd1, 4'd0, 4'd7, 8'd0);
        nop(7);
        for (int i = 0; i < BURST; i++) begin
            n_checks++;
            if (o_vec[t + CL + i][14] !== 1'b1 || o_vec[t + CL + i][13:6] !== d[i]) begin
                n_fail++;
                $display("FAIL raw_b2b beat %0d: valid/data %b/%h required 1/%h",
                         i, o_vec[t + CL + i][14], o_vec[t + CL + i][13:6], d[i]);
            end
        end
        n_checks++;
        if (cmd_error !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_b2b_no_error: got %b required 0", cmd_error);
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_closed_bank();
        int w0 = cyc;
        step(3'd2, 2'd2, 4'd0, 4'd0, 8'd0);
        nop(6);
        n_checks++;
        if (cmd_error !== 1'b1) begin
            n_fail++;
            $display("FAIL closed_rd_error: got %b required 1", cmd_error);
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k][14] !== 1'b0 || o_vec[k][5] !== 1'b0) begin
                n_fail++;
                $display("FAIL closed_rd_quiet cycle %0d: valid/busy %b/%b required 0/0", k, o_vec[k][14], o_vec[k][5]);
            end
        end
        step(3'd1, 2'd2, 4'd1, 4'd0, 8'd0);
        n_checks++;
        if (open_mask !== 4'b0111 || cmd_error !== 1'b1) begin
            n_fail++;
            $display("FAIL act_after_error: mask/err %b/%b required 0111/1", open_mask, cmd_error);
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL closed_bank cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_busy_errors();
        int w0 = cyc;
        int t, nb;
        logic [7:0] d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        t = cyc;
        step(3'd2, 2'd1, 4'd0, 4'd2, 8'd0);
        nop(3);
        step(3'd1, 2'd3, 4'd9, 4'd0, 8'd0);
        nop(4);
        for (int i = 0; i < BURST; i++) begin
            n_checks++;
            if (o_vec[t + CL + i][14] !== 1'b1 || o_vec[t + CL + i][13:6] !== d[i]) begin
                n_fail++;
                $display("FAIL act_during_read beat %0d: valid/data %b/%h required 1/%h",
                         i, o_vec[t + CL + i][14], o_vec[t + CL + i][13:6], d[i]);
            end
        end
        n_checks++;
        if (open_mask[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL act_during_read_ignored: mask %b required bank3 closed", open_mask);
        end
        step(3'd5, 2'd0, 4'd0, 4'd0, 8'd0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ref_with_open_bank: busy %b required 0", busy);
        end
        for (int b = 0; b < 4; b++) step(3'd4, 2'(b), 4'd0, 4'd0, 8'd0);
        t = cyc;
        step(3'd5, 2'd0, 4'd0, 4'd0, 8'd0);
        nop(8);
        nb = 0;
        for (int i = 1; i <= 9; i++) if (o_vec[t + i][5] === 1'b1) nb++;
        n_checks++;
        if (nb !== TRFC || o_vec[t + 1][5] !== 1'b1) begin
            n_fail++;
            $display("FAIL refresh_len: busy cycles %0d first %b required %0d 1", nb, o_vec[t + 1][5], TRFC);
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL busy_errors cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0 = cyc;
        int t;
        logic [7:0] d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        step(3'd1, 2'd1, 4'd5, 4'd0, 8'd0);
        t = cyc;
        step(3'd2, 2'd1, 4'd0, 4'd2, 8'd0);
        nop(4);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA2) begin
            n_fail++;
            $display("FAIL reset_mid_setup: valid/data %b/%h required 1/a2", rd_valid, rd_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || open_mask !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: valid/data/mask/busy %b/%h/%b/%b required 0/00/0000/0",
                     rd_valid, rd_data, open_mask, busy);
        end
        nop(2);
        rst_n = 1'b1;
        step(3'd1, 2'd1, 4'd5, 4'd0, 8'd0);
        t = cyc;
        step(3'd2, 2'd1, 4'd0, 4'd2, 8'd0);
        nop(7);
        for (int i = 0; i < BURST; i++) begin
            n_checks++;
            if (o_vec[t + CL + i][14] !== 1'b1 || o_vec[t + CL + i][13:6] !== d[i]) begin
                n_fail++;
                $display("FAIL reset_retains beat %0d: valid/data %b/%h required 1/%h",
                         i, o_vec[t + CL + i][14], o_vec[t + CL + i][13:6], d[i]);
            end
        end
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    task automatic test_random();
        int w0 = cyc;
        int sel;
        logic [2:0] c;
        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 11);
            if      (sel <= 2)  c = 3'd0;
            else if (sel <= 4)  c = 3'd1;
            else if (sel <= 6)  c = 3'd2;
            else if (sel == 7)  c = 3'd3;
            else if (sel <= 9)  c = 3'd4;
            else if (sel == 10) c = 3'd5;
            else                c = 3'($urandom_range(6, 7));
            if (n == 500) rst_n = 1'b0;
            step(c, 2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            rst_n = 1'b1;
        end
        nop(12);
        for (int k = w0 + 1; k <= cyc; k++) begin
            n_checks++;
            if (o_vec[k] !== e_vec[k]) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h required %h", k, o_vec[k], e_vec[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd   = 3'd0;
        bank  = 2'd0;
        row   = 4'd0;
        col   = 4'd0;
        wdata = 8'd0;
        model_reset();
        test_reset();
        test_fill();
        test_write_read();
        test_column_wrap();
        test_back_to_back();
        test_closed_bank();
        test_busy_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
